// File: rtl/subneg_mem_responder.sv
// Bus-side responder for the SUBNEG core: address latch, byte memory, output
// port and a valid/ready preload port, all decoded from strobe edges on clk.
module subneg_mem_responder #(
  parameter int unsigned AW       = 8,
  parameter int unsigned OUT_ADDR = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    bus_in,
  input  logic          bus_oe,
  input  logic          latch_clk,
  input  logic          mem_oe_n,
  input  logic          mem_we_n,
  input  logic          out_clk,
  output logic [7:0]    rsp_data,
  output logic          rsp_drive,
  output logic [7:0]    out_port,
  output logic          out_valid,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          conflict
);

  localparam int unsigned DEPTH = 1 << AW;

  // The output port is strobed by out_clk; OUT_ADDR only documents the core's map.
  if (OUT_ADDR >= DEPTH) begin : g_out_addr_outside_memory
  end

  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    out_port_q, out_port_d;
  logic          out_valid_q, out_valid_d;
  logic          conflict_q, conflict_d;
  logic          latch_prev_q, latch_prev_d;
  logic          we_n_prev_q, we_n_prev_d;
  logic          out_prev_q, out_prev_d;

  logic          lat_rise;
  logic          we_fall;
  logic          out_rise;
  logic          bus_wr;
  logic          ld_fire;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0]    mem_wr_data;

  always_comb begin
    lat_rise = latch_clk & ~latch_prev_q;
    we_fall  = ~mem_we_n & we_n_prev_q;
    out_rise = out_clk & ~out_prev_q;
  end

  // Bus writes win the single memory port; a write edge seen during reset is dropped.
  always_comb begin
    ld_ready    = ~we_fall;
    ld_fire     = ld_valid & ld_ready;
    bus_wr      = we_fall & ~reset;
    mem_wr_en   = bus_wr | ld_fire;
    mem_wr_addr = ld_addr;
    mem_wr_data = ld_data;
    if (bus_wr) begin
      mem_wr_addr = addr_q;
      mem_wr_data = bus_in;
    end
  end

  always_comb begin
    addr_d       = addr_q;
    out_port_d   = out_port_q;
    out_valid_d  = out_rise;
    conflict_d   = conflict_q | (bus_oe & rsp_drive);
    latch_prev_d = latch_clk;
    we_n_prev_d  = mem_we_n;
    out_prev_d   = out_clk;
    if (lat_rise) begin
      addr_d = bus_in[AW-1:0];
    end
    if (out_rise) begin
      out_port_d = bus_in;
    end
  end

  // Edge history resets to the asserted levels so lines held active across
  // reset release do not register as fresh edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      out_port_q   <= '0;
      out_valid_q  <= 1'b0;
      conflict_q   <= 1'b0;
      latch_prev_q <= 1'b1;
      we_n_prev_q  <= 1'b0;
      out_prev_q   <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      out_port_q   <= out_port_d;
      out_valid_q  <= out_valid_d;
      conflict_q   <= conflict_d;
      latch_prev_q <= latch_prev_d;
      we_n_prev_q  <= we_n_prev_d;
      out_prev_q   <= out_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end
  end

  always_comb begin
    rsp_drive = ~mem_oe_n;
    rsp_data  = '0;
    if (rsp_drive) begin
      rsp_data = mem_q[addr_q];
    end
  end

  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;
  assign conflict  = conflict_q;

endmodule

// File: tb/tb_subneg_mem_responder.sv
// Directed bench for subneg_mem_responder: emulates the core's bus cycles and
// checks reads, writes, output strobes, loader handshake, conflict and reset.
module tb_subneg_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       bus_oe;
  logic       latch_clk;
  logic       mem_oe_n;
  logic       mem_we_n;
  logic       out_clk;
  logic [7:0] rsp_data;
  logic       rsp_drive;
  logic [7:0] out_port;
  logic       out_valid;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  subneg_mem_responder #(.AW(8), .OUT_ADDR(255)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_oe(bus_oe),
    .latch_clk(latch_clk), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .out_clk(out_clk), .rsp_data(rsp_data), .rsp_drive(rsp_drive),
    .out_port(out_port), .out_valid(out_valid), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_latch(input logic [7:0] a);
    bus_in = a; bus_oe = 1'b1; latch_clk = 1'b1;
    step();
    latch_clk = 1'b0; bus_oe = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
    bus_latch(a);
    mem_oe_n = 1'b0;
    #1;
    v = rsp_data;
    mem_oe_n = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_latch(a);
    bus_in = d; bus_oe = 1'b1; mem_we_n = 1'b0;
    step();
    mem_we_n = 1'b1; bus_oe = 1'b0;
    step();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    check("ld_ready_idle", ld_ready, 1);
    step();
    ld_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] v, fa, fb, fc, va, vb, r, pc;

    reset = 1'b1; bus_in = 8'h00; bus_oe = 1'b0; latch_clk = 1'b0;
    mem_oe_n = 1'b1; mem_we_n = 1'b1; out_clk = 1'b0;
    ld_valid = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    step();
    check("rst_addr", dut.addr_q, 0);
    check("rst_out_port", out_port, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_conflict", conflict, 0);
    check("idle_rsp_drive", rsp_drive, 0);
    check("idle_rsp_data", rsp_data, 0);
    reset = 1'b0;
    step();

    // Preload and run one SUBNEG instruction through the bus
    load(8'd0, 8'd10); load(8'd1, 8'd11); load(8'd2, 8'd3);
    load(8'd10, 8'd5); load(8'd11, 8'd7); load(8'h60, 8'h07);
    pc = 8'd0;
    bus_read(pc, fa);            check("fetch_a", fa, 10);
    bus_read(pc + 8'd1, fb);     check("fetch_b", fb, 11);
    bus_read(pc + 8'd2, fc);     check("fetch_c", fc, 3);
    bus_read(fa, va);            check("operand_a", va, 5);
    bus_read(fb, vb);            check("operand_b", vb, 7);
    r = vb - va;
    bus_write(fb, r);
    pc = r[7] ? fc : pc + 8'd3;
    check("pc_next", pc, 3);
    bus_read(8'd11, v);          check("mem11_result", v, 2);
    check("conflict_core", conflict, 0);

    // One write per low assertion of mem_we_n
    bus_latch(8'h40);
    bus_in = 8'hA5; bus_oe = 1'b1; mem_we_n = 1'b0;
    step();
    bus_in = 8'h11;
    repeat (4) step();
    mem_we_n = 1'b1; bus_oe = 1'b0;
    step();
    bus_read(8'h40, v);          check("we_once", v, 8'hA5);

    // Output port strobe held high for three cycles
    bus_in = 8'h3C; bus_oe = 1'b1; out_clk = 1'b1;
    step();
    check("out_port", out_port, 8'h3C);
    check("out_valid_c1", out_valid, 1);
    step();
    check("out_valid_c2", out_valid, 0);
    step();
    check("out_valid_c3", out_valid, 0);
    out_clk = 1'b0; bus_oe = 1'b0;
    step();
    bus_read(8'h40, v);          check("out_no_mem", v, 8'hA5);

    // Loader collides with a bus write edge
    bus_latch(8'h30);
    bus_in = 8'h55; bus_oe = 1'b1;
    ld_valid = 1'b1; ld_addr = 8'h20; ld_data = 8'h99; mem_we_n = 1'b0;
    #1;
    check("ld_ready_stall", ld_ready, 0);
    step();
    check("ld_ready_after", ld_ready, 1);
    step();
    ld_valid = 1'b0; mem_we_n = 1'b1; bus_oe = 1'b0;
    step();
    bus_read(8'h20, v);          check("ld_mem20", v, 8'h99);
    bus_read(8'h30, v);          check("wr_mem30", v, 8'h55);

    // Latch edge and write edge together: write goes to the old address
    bus_latch(8'h50);
    bus_in = 8'h60; bus_oe = 1'b1; latch_clk = 1'b1; mem_we_n = 1'b0;
    step();
    check("sim_new_addr", dut.addr_q, 8'h60);
    latch_clk = 1'b0; mem_we_n = 1'b1; bus_oe = 1'b0;
    step();
    bus_read(8'h50, v);          check("sim_old_addr_wr", v, 8'h60);
    bus_read(8'h60, v);          check("sim_new_addr_kept", v, 8'h07);

    // No write-to-read bypass in the commit cycle
    bus_latch(8'h40);
    bus_in = 8'h77; mem_we_n = 1'b0; mem_oe_n = 1'b0;
    #1;
    check("nobypass_old", rsp_data, 8'hA5);
    step();
    check("after_commit", rsp_data, 8'h77);
    mem_we_n = 1'b1; mem_oe_n = 1'b1;
    step();

    // Conflict is sticky
    mem_oe_n = 1'b0; bus_oe = 1'b1;
    step();
    mem_oe_n = 1'b1; bus_oe = 1'b0;
    check("conflict_set", conflict, 1);
    repeat (3) step();
    check("conflict_sticky", conflict, 1);

    // Reset with mem_we_n low and latch_clk high, released unchanged
    bus_latch(8'h40);
    bus_in = 8'hEE; bus_oe = 1'b1; latch_clk = 1'b1; mem_we_n = 1'b0; reset = 1'b1;
    step();
    check("mid_rst_addr", dut.addr_q, 0);
    check("mid_rst_out_port", out_port, 0);
    check("mid_rst_conflict", conflict, 0);
    reset = 1'b0;
    repeat (3) step();
    check("post_rst_addr", dut.addr_q, 0);
    mem_we_n = 1'b1; latch_clk = 1'b0; bus_oe = 1'b0;
    step();
    bus_read(8'h40, v);          check("post_rst_mem40", v, 8'h77);
    bus_read(8'h00, v);          check("post_rst_mem00", v, 8'd10);
    check("post_rst_conflict", conflict, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subneg_mem_responder.md
# subneg_mem_responder

Bus-side responder for the SUBNEG core's external memory interface. It replaces the discrete address latch, 256×8 SRAM and output latch with one synchronous block, so the core can run closed-loop in simulation and FPGA bring-up. It decodes the core's shared 8-bit bus using four control lines:
- `latch_clk`: address latch strobe.
- `mem_oe_n`: read enable.
- `mem_we_n`: write enable.
- `out_clk`: output-port strobe.

A valid/ready load port preloads program memory.

## Interface
Parameters:
- `AW`, default 8: address width; memory depth is 2^AW bytes.
- `OUT_ADDR`, default 255: address the core treats as the output port. Informational only; the responder uses `out_clk`, not address decode.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `bus_in` input 8: bus value driven by the core (`uio_out`).
- `bus_oe` input 1: core output enable (any bit of `uio_oe`; the core drives all-or-nothing).
- `latch_clk` input 1: rising edge captures the address from `bus_in`.
- `mem_oe_n` input 1: low means the responder drives read data.
- `mem_we_n` input 1: falling edge writes `bus_in` to memory.
- `out_clk` input 1: rising edge captures `bus_in` into the output port.
- `rsp_data` output 8: read data toward the core (`uio_in`).
- `rsp_drive` output 1: responder is driving `rsp_data`.
- `out_port` output 8: last value strobed by `out_clk`.
- `out_valid` output 1: one-cycle pulse when `out_port` updates.
- `ld_valid` input 1: load request.
- `ld_ready` output 1: load accepted this cycle when `ld_valid` is also high.
- `ld_addr` input AW: load address.
- `ld_data` input 8: load data.
- `conflict` output 1: sticky; set when `bus_oe` and `rsp_drive` are both 1.

## Operation
Edge detection:
- Registers `latch_prev`, `we_n_prev` and `out_prev` sample their lines every cycle.
- `lat_rise = latch_clk & ~latch_prev`.
- `we_fall = ~mem_we_n & we_n_prev`.
- `out_rise = out_clk & ~out_prev`.

Address latch:
- On `lat_rise`, `addr_q <= bus_in[AW-1:0]`.
- `addr_q` holds otherwise, including while `latch_clk` stays high.

Read path:
- `rsp_drive = ~mem_oe_n`, combinational.
- `rsp_data = mem[addr_q]` when `rsp_drive`, else `8'h00`. This is an asynchronous read of the array and is combinational from `addr_q`.

Write:
- On `we_fall`, `mem[addr_q] <= bus_in`.
- Exactly one write per low assertion, however long `mem_we_n` stays low.
- Writes commit regardless of address.

Output port:
- On `out_rise`, `out_port <= bus_in` and `out_valid <= 1` for exactly one cycle.
- Fires independently of `we_fall`.

Loader:
- `ld_ready = ~we_fall`, so bus writes take priority.
- When `ld_valid & ld_ready`, `mem[ld_addr] <= ld_data`.
- A stalled load holds until accepted; the bench must keep `ld_addr`/`ld_data` stable.

Conflict:
- `conflict <= 1` on any cycle with `bus_oe & rsp_drive`.
- Cleared only by reset.

Simultaneous events:
- `lat_rise` and `we_fall` in the same cycle: the write uses the old `addr_q`, and the new address takes effect next cycle.
- `lat_rise` and `out_rise` in the same cycle: both act.

Reset values (one cycle with `reset` = 1):
- `addr_q` = 0, `out_port` = 0, `out_valid` = 0, `conflict` = 0.
- Edge registers are set to their asserted levels, so no spurious edge is detected when reset releases: `latch_prev` = 1, `we_n_prev` = 0, `out_prev` = 1.
- Memory contents are not cleared.
- A reset mid-write with `mem_we_n` still low produces no write after release; the next write needs a fresh high→low transition.

## Timing
- Address: captured at the first edge where `latch_clk` samples 1. It is usable for reads from the next cycle, one cycle of latency.
- Read: `rsp_data` is valid in the same cycle `mem_oe_n` samples low, provided `addr_q` was updated at least one edge earlier. The core latches at state 1, drops OE at state 2 and samples at state 3, which meets this.
- Write: commits at the edge where `mem_we_n` first samples 0, and is visible on `rsp_data` from the next cycle.
  - A read of the same address in the commit cycle returns the old value; there is no bypass.
- Output: `out_port` and `out_valid` update at the edge where `out_clk` first samples 1.
- Loader: one byte per cycle when not stalled.

## Test plan
- Preload, then fetch:
  - Stimulus: load mem[0..2] = 10, 11, 3 and mem[10] = 5, mem[11] = 7. Run the core one full instruction.
  - Required: fetches return 10, 11, 3; operands return 5, 7; mem[11] becomes 2; PC advances to 3; `conflict` stays 0.
- Write edge count:
  - Stimulus: latch 0x40 from the bus, drive `bus_in` = 0xA5, hold `mem_we_n` low for 5 cycles while changing `bus_in` to 0x11.
  - Required: mem[0x40] = 0xA5 only.
- Output port:
  - Stimulus: `bus_in` = 0x3C; raise `out_clk` and hold it for 3 cycles.
  - Required: `out_port` = 0x3C; `out_valid` high for exactly 1 cycle; memory unchanged.
- Loader vs write collision:
  - Stimulus: `ld_valid` held with addr 0x20, data 0x99; `we_fall` occurs in the same cycle to addr 0x30, data 0x55.
  - Required: `ld_ready` = 0 that cycle; next cycle the load is accepted; mem[0x20] = 0x99 and mem[0x30] = 0x55.
- Conflict:
  - Stimulus: `mem_oe_n` = 0 with `bus_oe` = 1 for one cycle.
  - Required: `conflict` = 1 and stays 1 until reset.
- Reset mid-operation:
  - Stimulus: assert reset while `mem_we_n` = 0 and `latch_clk` = 1, then release with both unchanged.
  - Required: no write; `addr_q` = 0; `out_port` = 0; memory preserved.
